// File: rtl/mem_arbiter_if.sv
// Request/response bundle used for both core-side ports and the external memory port.
// master issues requests and consumes responses; slave is the responding end.
interface mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (output valid, instr, addr, wdata, wstrb, input  rdata, ready);
  modport slave  (input  valid, instr, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// Two-into-one memory arbiter: merges the core's imem/dmem ports onto one memory port with a
// single outstanding transaction. Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin ties.
module mem_arbiter (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  imem,
  mem_arbiter_if.slave  dmem,
  mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_e state_q, state_d;
  req_t   pend_i_q, pend_i_d;
  req_t   pend_d_q, pend_d_d;
  req_t   issue_q, issue_d;
  req_t   in_i, in_d;
  req_t   cand_i, cand_d;
  logic   take_i, take_d;
  logic   arb_en;
  logic   pick_i;
  logic   grant_i, grant_d;
  logic   resp_i, resp_d;

  assign in_i = '{valid: imem.valid, instr: imem.instr, addr: imem.addr,
                  wdata: imem.wdata, wstrb: imem.wstrb};
  assign in_d = '{valid: dmem.valid, instr: dmem.instr, addr: dmem.addr,
                  wdata: dmem.wdata, wstrb: dmem.wstrb};

  // A port whose response returns this cycle is no longer in flight, so it may re-request now.
  assign take_i = in_i.valid && !pend_i_q.valid && !((state_q == BUSY_I) && !mem.ready);
  assign take_d = in_d.valid && !pend_d_q.valid && !((state_q == BUSY_D) && !mem.ready);

  assign arb_en = (state_q == IDLE) || mem.ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    cand_i       = pend_i_q.valid ? pend_i_q : in_i;
    cand_i.valid = pend_i_q.valid || take_i;
    cand_d       = pend_d_q.valid ? pend_d_q : in_d;
    cand_d.valid = pend_d_q.valid || take_d;
  end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  assign pick_i = cand_i.valid && (!cand_d.valid || last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (grant_i)      last_d_d = 1'b0;
    else if (grant_d) last_d_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) last_d_q <= 1'b1;
    else       last_d_q <= last_d_d;
  end
`else
  assign pick_i = cand_i.valid && !cand_d.valid;
`endif

  assign grant_i = arb_en && pick_i;
  assign grant_d = arb_en && cand_d.valid && !pick_i;

  always_comb begin
    state_d       = state_q;
    pend_i_d      = pend_i_q;
    pend_d_d      = pend_d_q;
    issue_d       = issue_q;
    issue_d.valid = 1'b0;

    if (take_i) pend_i_d = in_i;
    if (take_d) pend_d_d = in_d;

    if (grant_i) begin
      pend_i_d = '0;
      issue_d  = cand_i;
      state_d  = BUSY_I;
    end else if (grant_d) begin
      pend_d_d = '0;
      issue_d  = cand_d;
      state_d  = BUSY_D;
    end else if (arb_en) begin
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: payload registers are reset along with the valid bits because mem_* must read 0.
      state_q  <= IDLE;
      pend_i_q <= '0;
      pend_d_q <= '0;
      issue_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q  <= state_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      issue_q  <= issue_d;
    end
  end

  // Responses route to the owner of the outstanding transaction; stray mem_ready in IDLE is dropped.
  assign resp_i = (state_q == BUSY_I) && mem.ready;
  assign resp_d = (state_q == BUSY_D) && mem.ready;

  assign imem.ready = resp_i;
  assign imem.rdata = resp_i ? mem.rdata : 32'h0;
  assign dmem.ready = resp_d;
  assign dmem.rdata = resp_d ? mem.rdata : 32'h0;

  assign mem.valid = issue_q.valid;
  assign mem.instr = issue_q.instr;
  assign mem.addr  = issue_q.addr;
  assign mem.wdata = issue_q.wdata;
  assign mem.wstrb = issue_q.wstrb;

  a_one_grant : assert property (@(posedge clock) disable iff (reset) !(grant_i && grant_d));
  a_valid_busy : assert property (@(posedge clock) disable iff (reset)
                                  mem.valid |-> (state_q != IDLE));

endmodule
